// File: rtl/ocm_noise_reader_pkg.sv
// Shared types and default widths for the OCM noise reader.
package ocm_noise_pkg;

  localparam int ADDR_W_DEF     = 14;
  localparam int DATA_W_DEF     = 64;
  localparam int SAMPLE_W_DEF   = 16;
  localparam int ADDR_STEP_DEF  = 2;
  localparam int RD_LATENCY_DEF = 1;
  localparam int FIFO_DEPTH_DEF = 4;

  // Samples carried by one memory word.
  localparam int LANES = DATA_W_DEF / SAMPLE_W_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } noise_rd_state_t;

endpackage

// File: rtl/ocm_noise_reader_if.sv
// Memory port-2 bus and noise sample stream bundles.

// Read side of the OCM 64-bit port; master = the reader.
interface ocm_mem_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write;
  logic [DATA_W-1:0] readdata;

  modport master (output address, chipselect, write, input readdata);
  modport slave  (input address, chipselect, write, output readdata);
endinterface

// Valid/ready sample stream; master = the sample source.
interface noise_stream_if #(
  parameter int SAMPLE_W = 16
);
  logic [SAMPLE_W-1:0] data;
  logic                valid;
  logic                ready;

  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/ocm_noise_reader_word_fifo.sv
// Small synchronous word FIFO with occupancy count; push and pop may
// happen in the same cycle. DEPTH must be a power of two >= 2.
module ocm_word_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         do_push, do_pop, full;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && (count_q != '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ocm_noise_reader.sv
// Sweeps an address window on OCM port 2, prefetches words into a small
// buffer and streams them out as 16-bit noise samples, lane 0 first.
module ocm_noise_reader
  import ocm_noise_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int ADDR_STEP  = ADDR_STEP_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              restart,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  ocm_mem_if.master         mem,
  noise_stream_if.master    smp,
  output logic              wrap_pulse,
  output logic              busy
);

  localparam int NUM_LANES = DATA_W / SAMPLE_W;
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int CRD_W     = CNT_W + 1;

  noise_rd_state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cs_q, cs_d;
  logic              wrap_q, wrap_d;
  logic              loaded_q, loaded_d;
  logic [RD_LATENCY:1] vld_pipe_q, vld_pipe_d;
  logic [LANE_W-1:0] lane_q, lane_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [DATA_W-1:0] head_word;
  logic [NUM_LANES-1:0][SAMPLE_W-1:0] head_lanes;
  logic [CRD_W-1:0]  in_flight, credits_used;
  logic              issue, push, pop, accept, last_lane;

  // Reads in flight: the registered strobe plus every stage of the return pipe.
  // The last pipe stage is being pushed this cycle and still holds its credit.
  always_comb begin
    in_flight = CRD_W'(cs_q);
    for (int i = 1; i <= RD_LATENCY; i++) in_flight = in_flight + CRD_W'(vld_pipe_q[i]);
    credits_used = in_flight + CRD_W'(fifo_count);
  end

  // A read issues only while fetching, with a free buffer slot reserved for it.
  assign issue = (state_q == FETCH) && loaded_q && !restart &&
                 (credits_used < CRD_W'(FIFO_DEPTH));

  // Data returns exactly RD_LATENCY cycles after the strobe reaches memory.
  assign push = vld_pipe_q[RD_LATENCY];

  assign head_lanes = head_word;
  assign last_lane  = (lane_q == LANE_W'(NUM_LANES - 1));
  assign accept     = !fifo_empty && smp.ready;
  assign pop        = accept && last_lane;

  // Sequencer next state: FSM, address pointer, read strobe and lane index.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    cs_d     = 1'b0;
    wrap_d   = 1'b0;
    loaded_d = 1'b1;
    lane_d   = lane_q;

    vld_pipe_d[1] = cs_q;
    for (int i = 2; i <= RD_LATENCY; i++) vld_pipe_d[i] = vld_pipe_q[i-1];

    case (state_q)
      IDLE:    if (enable) state_d = FETCH;
      FETCH:   if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)               state_d = FETCH;
        else if (in_flight == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Restart (and the first cycle out of reset) reloads the pointer and
    // suppresses any issue; buffered and in-flight words are left alone.
    if (!loaded_q || restart) begin
      ptr_d = start_addr;
    end else if (issue) begin
      cs_d   = 1'b1;
      addr_d = ptr_q;
      if (ptr_q == end_addr) begin
        ptr_d  = start_addr;
        wrap_d = 1'b1;
      end else begin
        ptr_d = ptr_q + ADDR_W'(ADDR_STEP);
      end
    end

    if (accept) lane_d = last_lane ? '0 : lane_q + LANE_W'(1);
  end

  // Sequencer registers; all outputs to memory are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      addr_q     <= '0;
      cs_q       <= 1'b0;
      wrap_q     <= 1'b0;
      loaded_q   <= 1'b0;
      vld_pipe_q <= '0;
      lane_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      cs_q       <= cs_d;
      wrap_q     <= wrap_d;
      loaded_q   <= loaded_d;
      vld_pipe_q <= vld_pipe_d;
      lane_q     <= lane_d;
    end
  end

  ocm_word_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (mem.readdata),
    .pop   (pop),
    .rdata (head_word),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign mem.address    = addr_q;
  assign mem.chipselect = cs_q;
  assign mem.write      = 1'b0;
  assign wrap_pulse     = wrap_q;

  // Samples are raw bits of the head word; forced to zero when nothing is buffered.
  assign smp.valid = !fifo_empty;
  assign smp.data  = fifo_empty ? '0 : head_lanes[lane_q];
  assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: doc/ocm_noise_reader.md
Name: ocm_noise_reader

Overview:
- Streams stored noise samples out of the on-chip memory's 64-bit port (port 2).
- Sweeps a programmable address window, wraps at its end, and prefetches words into a small buffer.
- Unpacks each 64-bit word into 16-bit noise samples on a valid/ready stream for the downstream noise-injection stage.
- Sits directly between the on-chip memory and the channel noise adder.

Parameters:
- ADDR_W, 14, memory port-2 address width
- DATA_W, 64, memory port-2 data width
- SAMPLE_W, 16, output sample width; DATA_W must be a multiple of SAMPLE_W
- ADDR_STEP, 2, address increment per word read
- RD_LATENCY, 1, cycles from address/chipselect to valid readdata
- FIFO_DEPTH, 4, word buffer depth, power of two, >= RD_LATENCY+1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; 1 = issue reads
- restart  in  1  pulse; reload address pointer from start_addr
- start_addr  in  ADDR_W  first word address of window
- end_addr  in  ADDR_W  last word address of window, inclusive
- mem_address  out  ADDR_W  to OCM address2
- mem_chipselect  out  1  to OCM chipselect2; read strobe
- mem_write  out  1  to OCM write2; constant 0
- mem_readdata  in  DATA_W  from OCM readdata2
- sample_out  out  SAMPLE_W  noise sample
- sample_valid  out  1  sample_out is valid
- sample_ready  in  1  downstream accepts
- wrap_pulse  out  1  one-cycle pulse when the read of end_addr issues
- busy  out  1  reads outstanding or buffer non-empty

Behaviour:
- Reset values: mem_address=0, mem_chipselect=0, mem_write=0, sample_valid=0, sample_out=0, wrap_pulse=0, busy=0. Pointer, FIFO, lane index and in-flight tracking are cleared.
- Reset mid-operation discards in-flight reads; readdata returning afterwards is ignored.
- First cycle after reset deasserts: pointer loads start_addr.
- FSM states:
  - IDLE: go to FETCH when enable=1.
  - FETCH: go to DRAIN when enable=0.
  - DRAIN: wait for in-flight reads = 0, then go to IDLE. Go back to FETCH if enable returns first.
- Read issue happens in FETCH only, when in_flight + fifo_count < FIFO_DEPTH.
  - mem_chipselect=1 and mem_address=pointer in the issue cycle, both registered.
  - Pointer advances by ADDR_STEP modulo 2^ADDR_W.
  - If pointer == end_addr, the next pointer is start_addr and wrap_pulse=1 in the issue cycle.
- Read return: a RD_LATENCY-deep valid shift register tags issue cycles. mem_readdata is written to the FIFO exactly RD_LATENCY cycles after issue. The credit check guarantees no overflow, so no data is ever dropped.
- Unpack:
  - Head word is split into DATA_W/SAMPLE_W lanes, lane 0 = bits [SAMPLE_W-1:0] first.
  - sample_valid = FIFO non-empty; sample_out = current lane of the head word, combinational from the registered FIFO/lane index.
  - On sample_valid && sample_ready the lane index increments. After the last lane the head word pops and the lane returns to 0.
  - A pop and a push in the same cycle are both honoured.
- Samples are passed as raw two's-complement bits; no arithmetic.
- restart:
  - Pointer reloads start_addr next cycle; it has priority over an issue that cycle, so no read issues.
  - FIFO contents and in-flight reads are kept, so old-window samples drain first.
  - restart in IDLE reloads only.
- start_addr == end_addr: every read is that address, with wrap_pulse on each issue.
- end_addr not reachable from start_addr by ADDR_STEP: the pointer wraps at the 2^ADDR_W boundary and continues. Avoiding this is the user's responsibility; nothing is flagged.
- enable=0 with a non-empty FIFO: samples stay available until consumed.
- busy = (state != IDLE) || FIFO non-empty.

Decomposition:
- Package ocm_noise_pkg holds:
  - state enum noise_rd_state_t {IDLE, FETCH, DRAIN}
  - constant LANES = DATA_W/SAMPLE_W
  - localparam-style default widths
- One natural sub-module, ocm_word_fifo: synchronous FIFO with DATA_W width, FIFO_DEPTH depth and count output. It is instantiated once for the prefetch buffer.

Test Plan:
- Memory model holds word at A = {A+3,A+2,A+1,A} (16-bit lanes), RD_LATENCY=1. start 0x200, end 0x218, enable=1, sample_ready=1 -> addresses 0x200,0x202,…,0x218 then 0x200 again. wrap_pulse appears once per 13 reads. Samples 0x0200,0x0201,0x0202,0x0203,0x0202,… in order.
- Same setup with sample_ready=0 for 20 cycles -> exactly 4 reads issue, then mem_chipselect stays 0. sample_valid=1 holding 0x0200. Releasing ready yields an uninterrupted sequence with no skipped or duplicated sample.
- Toggle sample_ready every other cycle over 104 accepted samples -> output equals the reference sequence, 2 full windows, with 2 wrap_pulses.
- enable dropped after 3 issues -> state goes DRAIN then IDLE after the last return. The 12 buffered samples remain consumable; busy falls after the last pop.
- restart while start_addr is changed to 0x000 mid-sweep -> buffered 0x02xx samples drain first, then samples 0x0000,0x0001,…; no read issues in the restart cycle.
- Assert reset with 2 reads in flight and FIFO at 3 -> all outputs are at reset values within the same cycle (async). Returning readdata is ignored, and after release the first address is start_addr.
